// File: rtl/source_pkg.sv
// Shared types and defaults for the serial pattern detector.
package source_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int         SOURCE_W_DEFAULT       = 4;
  localparam logic [3:0] SOURCE_PATTERN_DEFAULT = 4'b1011;

  // Fill counter must hold the value W itself, hence W+1 states.
  function automatic int source_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/source_window.sv
// Sliding W-bit history with clear-and-load and a fill counter saturating at W.
// window_o/full_o present the contents as they will be after the current edge.
module source_window
  import source_pkg::*;
#(
  parameter int W = SOURCE_W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_i,
  input  logic         load_i,
  output logic [W-1:0] window_o,
  output logic         full_o
);

  localparam int CW = source_cnt_width(W);

  logic [W-1:0]  win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    win_d = {win_q[W-2:0], in_i};
    cnt_d = (cnt_q >= CW'(W)) ? cnt_q : cnt_q + CW'(1);
    if (load_i) begin
      win_d = {{(W-1){1'b0}}, in_i};
      cnt_d = CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      win_q <= '0;
      cnt_q <= '0;
    end else begin
      win_q <= win_d;
      cnt_q <= cnt_d;
    end
  end

  assign window_o = win_d;
  assign full_o   = (cnt_d >= CW'(W));

endmodule

// File: rtl/source.sv
// Serial pattern detector: registered one-cycle pulse when the last W bits equal PATTERN.
// SOURCE_NONOVERLAP_EN: the edge after a match restarts the window so matches never share bits.
module source
  import source_pkg::*;
#(
  parameter int         W       = SOURCE_W_DEFAULT,
  parameter logic [W-1:0] PATTERN = W'(SOURCE_PATTERN_DEFAULT)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in,
  input  logic x,
  output logic out
);

  state_e       state_q, state_d;
  logic         out_q, out_d;
  logic         restart;
  logic [W-1:0] window;
  logic         full;

`ifdef SOURCE_NONOVERLAP_EN
  assign restart = x | out_q;
`else
  assign restart = x;
`endif

  source_window #(.W(W)) u_window (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_i     (in),
    .load_i   (restart),
    .window_o (window),
    .full_o   (full)
  );

  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    case (state_q)
      FILL:    if (!restart && full) state_d = RUN;
      RUN:     if (restart) state_d = FILL;
      default: state_d = FILL;
    endcase
    if (restart) state_d = FILL;
    // A restart edge holds a single bit, so it can never complete a match.
    out_d = (state_d == RUN) && (window == PATTERN);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FILL;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_source.sv
// Directed and long-stream checks of the serial pattern detector (W=4, PATTERN=1011).
module tb_source;

`ifdef SOURCE_NONOVERLAP_EN
  localparam bit NONOV = 1'b1;
`else
  localparam bit NONOV = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic in      = 1'b0;
  logic x       = 1'b0;
  logic out;

  int checks = 0;
  int errors = 0;

  source #(.W(4), .PATTERN(4'b1011)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (in),
    .x       (x),
    .out     (out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge with the given inputs; out is sampled 1 time unit after the edge.
  task automatic step(input string tag, input logic b, input logic r, input logic rn, input logic e);
    in      = b;
    x       = r;
    reset_n = rn;
    @(posedge clock);
    #1;
    check(tag, {31'd0, out}, {31'd0, e});
  endtask

  // Applies n bits MSB-first with x=0, reset_n=1; exp gives out after each edge.
  task automatic seq(input string tag, input logic [15:0] bits, input logic [15:0] exp, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, bits[i], 1'b0, 1'b1, exp[i]);
  endtask

  task automatic do_reset(input string tag);
    step(tag, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  logic [3:0] mwin;
  int         mcnt;
  logic       mout;
  logic       b;

  initial begin
    // Reset hold with in=1 asserted.
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    // First three bits never match, fourth completes 1011, then pulse drops.
    seq("single", 16'b10110, 16'b00010, 5);

    // Overlap: 1011011.
    do_reset("rst_ovl");
    seq("overlap", 16'b1011011, {9'd0, 6'b000100, ~NONOV}, 7);

    // Restart on the completing edge suppresses the match; new window then completes.
    do_reset("rst_rs");
    seq("restart_pre", 16'b101, 16'b000, 3);
    step("restart_edge", 1'b1, 1'b1, 1'b1, 1'b0);
    seq("restart_post", 16'b011, 16'b001, 3);

    // Reset mid-pattern discards history.
    do_reset("rst_mid0");
    seq("mid_pre", 16'b101, 16'b000, 3);
    do_reset("rst_mid");
    seq("mid_post", 16'b1011, 16'b0001, 4);

    // Long random stream against a reference model.
    do_reset("rst_long");
    mwin = 4'd0;
    mcnt = 0;
    mout = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      b = 1'($urandom_range(0, 1));
      if (NONOV && mout) begin
        mwin = {3'b000, b};
        mcnt = 1;
      end else begin
        mwin = {mwin[2:0], b};
        if (mcnt < 4) mcnt++;
      end
      mout = (mcnt >= 4) && (mwin == 4'b1011);
      step("long", b, 1'b0, 1'b1, mout);
    end
    // Count stays saturated at W with a run of zeros (no match can restart it).
    seq("tail", 16'b0000, 16'b0000, 4);
    check("fill_cnt", 32'(dut.u_window.cnt_q), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
